// File: rtl/dram_dq_wrser.sv
// dram_dq_wrser
//   Per-DQ write serializer. Queues write bursts in a small FIFO, then
//   frames each one for the pad as a preamble, 2 or 4 DDR beats and a
//   postamble. Back-to-back bursts are streamed without a gap. While one
//   burst is on the wire, the next burst can be queued.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing on the wire; all pad outputs 0
//   PRE   | one-cycle preamble; driver and pad window on, data 0
//   BURST | one DDR beat per cycle from the current entry
//   POST  | one-cycle postamble; driver off, pad window still on
//
// Ports
//   clk                   single clock, rising edge
//   arst_l                asynchronous active-low reset
//   wr_req                write-burst request (accepted when wr_req & wr_rdy)
//   wr_data[7:0]          burst bits for one DQ line, bit 0 goes first
//   burst_length_four     1 = 4-bit burst (wr_data[3:0]), 0 = 8-bit burst
//   wr_rdy                FIFO not full
//   data_pos / data_neg   rising / falling half of the current DDR beat
//   dram_io_drive_enable  pad output driver enable
//   dram_io_pad_enable    pad window enable (preamble through postamble)
//   busy                  FSM not idle or FIFO not empty
//   fifo_cnt              number of queued entries
module dram_dq_wrser #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          arst_l,
  input  logic                          wr_req,
  input  logic [7:0]                    wr_data,
  input  logic                          burst_length_four,
  output logic                          wr_rdy,
  output logic                          data_pos,
  output logic                          data_neg,
  output logic                          dram_io_drive_enable,
  output logic                          dram_io_pad_enable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } state_t;

  // FIFO storage: {wr_data, burst_length_four}
  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [5:0]    shift_q, shift_d;      // bits not yet sent, next pair in [1:0]
  logic          bl4_q, bl4_d;

  logic          data_pos_q, data_pos_d;
  logic          data_neg_q, data_neg_d;
  logic          drive_en_q, drive_en_d;
  logic          pad_en_q, pad_en_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          last_beat;
  logic [8:0]    head;

  // Readiness is taken from the registered count only, so a pop in the
  // same cycle never opens a slot for a push.
  assign wr_rdy     = (cnt_q != FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = wr_req & wr_rdy;
  assign head       = fifo_mem[rd_ptr_q];
  assign last_beat  = (beat_q == (bl4_q ? 2'd1 : 2'd3));

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {wr_data, burst_length_four};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_q     <= 2'd0;
      shift_q    <= 6'd0;
      bl4_q      <= 1'b0;
      data_pos_q <= 1'b0;
      data_neg_q <= 1'b0;
      drive_en_q <= 1'b0;
      pad_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      bl4_q      <= bl4_d;
      data_pos_q <= data_pos_d;
      data_neg_q <= data_neg_d;
      drive_en_q <= drive_en_d;
      pad_en_q   <= pad_en_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = PRE;
        end
      end
      PRE: begin
        // The entry that triggered PRE is still queued; it cannot drain.
        state_d = BURST;
        pop     = 1'b1;
      end
      BURST: begin
        if (last_beat) begin
          if (!fifo_empty) begin
            state_d = BURST;
            pop     = 1'b1;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        state_d = fifo_empty ? IDLE : PRE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs, registered by computing them for the state being entered
  // ---------------------------------------------------------------------
  always_comb begin
    data_pos_d = 1'b0;
    data_neg_d = 1'b0;
    drive_en_d = 1'b0;
    pad_en_d   = 1'b0;
    beat_d     = beat_q;
    shift_d    = shift_q;
    bl4_d      = bl4_q;
    case (state_d)
      PRE: begin
        drive_en_d = 1'b1;
        pad_en_d   = 1'b1;
      end
      BURST: begin
        drive_en_d = 1'b1;
        pad_en_d   = 1'b1;
        if (pop) begin
          // Beat 0 of the freshly popped entry; the length stored with the
          // entry governs the whole burst.
          data_pos_d = head[1];
          data_neg_d = head[2];
          shift_d    = head[8:3];
          bl4_d      = head[0];
          beat_d     = 2'd0;
        end else begin
          data_pos_d = shift_q[0];
          data_neg_d = shift_q[1];
          shift_d    = {2'b00, shift_q[5:2]};
          beat_d     = beat_q + 2'd1;
        end
      end
      POST: begin
        pad_en_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign data_pos             = data_pos_q;
  assign data_neg             = data_neg_q;
  assign dram_io_drive_enable = drive_en_q;
  assign dram_io_pad_enable   = pad_en_q;
  assign busy                 = (state_q != IDLE) || !fifo_empty;
  assign fifo_cnt             = cnt_q;

endmodule

// File: tb/tb_dram_dq_wrser.sv
module tb_dram_dq_wrser;

  logic       clk;
  logic       arst_l;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       burst_length_four;
  logic       wr_rdy;
  logic       data_pos;
  logic       data_neg;
  logic       dram_io_drive_enable;
  logic       dram_io_pad_enable;
  logic       busy;
  logic [1:0] fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dram_dq_wrser #(.FIFO_DEPTH(2)) dut (
    .clk                  (clk),
    .arst_l               (arst_l),
    .wr_req               (wr_req),
    .wr_data              (wr_data),
    .burst_length_four    (burst_length_four),
    .wr_rdy               (wr_rdy),
    .data_pos             (data_pos),
    .data_neg             (data_neg),
    .dram_io_drive_enable (dram_io_drive_enable),
    .dram_io_pad_enable   (dram_io_pad_enable),
    .busy                 (busy),
    .fifo_cnt             (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       bl4;
    logic       pos;
    logic       neg;
    logic       drv;
    logic       pad;
    logic       rdy;
    logic [1:0] cnt;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pos, input logic neg,
                            input logic drv, input logic pad, input logic rdy,
                            input logic [1:0] cnt, input logic bsy);
    check({tag, " data_pos"}, {7'd0, data_pos}, {7'd0, pos});
    check({tag, " data_neg"}, {7'd0, data_neg}, {7'd0, neg});
    check({tag, " drive_en"}, {7'd0, dram_io_drive_enable}, {7'd0, drv});
    check({tag, " pad_en"},   {7'd0, dram_io_pad_enable}, {7'd0, pad});
    check({tag, " wr_rdy"},   {7'd0, wr_rdy}, {7'd0, rdy});
    check({tag, " fifo_cnt"}, {6'd0, fifo_cnt}, {6'd0, cnt});
    check({tag, " busy"},     {7'd0, busy}, {7'd0, bsy});
  endtask

  // inputs applied before an edge, outputs expected after it
  task automatic add(input logic req, input logic [7:0] data, input logic bl4,
                     input logic pos, input logic neg, input logic drv, input logic pad,
                     input logic rdy, input logic [1:0] cnt, input logic bsy);
    vec_t v;
    v.req = req; v.data = data; v.bl4 = bl4;
    v.pos = pos; v.neg = neg; v.drv = drv; v.pad = pad;
    v.rdy = rdy; v.cnt = cnt; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  initial begin
    // single BL8 8'hB4; burst_length_four toggled to 1 mid-burst must not matter
    add(1, 8'hB4, 0,  0,0,0,0,1,2'd1,1);
    add(0, 8'h00, 1,  0,0,1,1,1,2'd1,1);  // PRE
    add(0, 8'h00, 1,  0,0,1,1,1,2'd0,1);  // beat 0
    add(0, 8'h00, 1,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 1,  1,1,1,1,1,2'd0,1);
    add(0, 8'h00, 1,  0,1,1,1,1,2'd0,1);  // beat 3
    add(0, 8'h00, 0,  0,0,0,1,1,2'd0,1);  // POST
    add(0, 8'h00, 0,  0,0,0,0,1,2'd0,0);  // IDLE
    // single BL4 8'hF6
    add(1, 8'hF6, 1,  0,0,0,0,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  0,1,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,0,1,2'd0,0);
    // back-to-back 8'hFF then 8'h00
    add(1, 8'hFF, 0,  0,0,0,0,1,2'd1,1);
    add(1, 8'h00, 0,  0,0,1,1,0,2'd2,1);  // PRE, full
    add(0, 8'h00, 0,  1,1,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  1,1,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  1,1,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  1,1,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);  // seamless second burst
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,0,1,2'd0,0);
    // full FIFO: A=01, then B=02, C=03, D=04 requested during A
    add(1, 8'h01, 0,  0,0,0,0,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd1,1);  // PRE
    add(0, 8'h00, 0,  1,0,1,1,1,2'd0,1);  // A b0
    add(1, 8'h02, 0,  0,0,1,1,1,2'd1,1);  // A b1, B pushed
    add(1, 8'h03, 0,  0,0,1,1,0,2'd2,1);  // A b2, C pushed
    add(1, 8'h04, 0,  0,0,1,1,0,2'd2,1);  // A b3, D refused
    add(1, 8'h04, 0,  0,1,1,1,1,2'd1,1);  // B b0 popped, D still refused
    add(1, 8'h04, 0,  0,0,1,1,0,2'd2,1);  // B b1, D pushed
    add(0, 8'h00, 0,  0,0,1,1,0,2'd2,1);
    add(0, 8'h00, 0,  0,0,1,1,0,2'd2,1);
    add(0, 8'h00, 0,  1,1,1,1,1,2'd1,1);  // C b0
    add(0, 8'h00, 0,  0,0,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd1,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);  // D b0
    add(0, 8'h00, 0,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,1,1,2'd0,1);  // POST
    add(0, 8'h00, 0,  0,0,0,0,1,2'd0,0);
    // mixed lengths: BL4 0A then BL8 55 (input bl4 held high afterwards)
    add(1, 8'h0A, 1,  0,0,0,0,1,2'd1,1);
    add(1, 8'h55, 0,  0,0,1,1,0,2'd2,1);
    add(0, 8'h00, 1,  0,1,1,1,1,2'd1,1);
    add(0, 8'h00, 1,  0,1,1,1,1,2'd1,1);
    add(0, 8'h00, 1,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 1,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 1,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 1,  1,0,1,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,1,1,2'd0,1);
    add(0, 8'h00, 0,  0,0,0,0,1,2'd0,0);

    arst_l = 1'b0;
    wr_req = 1'b0;
    wr_data = 8'h00;
    burst_length_four = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0,0,0,0,1,2'd0,0);
    arst_l = 1'b1;

    foreach (vecs[i]) begin
      wr_req = vecs[i].req;
      wr_data = vecs[i].data;
      burst_length_four = vecs[i].bl4;
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].pos, vecs[i].neg, vecs[i].drv,
                 vecs[i].pad, vecs[i].rdy, vecs[i].cnt, vecs[i].bsy);
    end

    // reset mid-burst: B4 on the wire, FF queued, reset at beat 1
    wr_req = 1'b1; wr_data = 8'hB4; burst_length_four = 1'b0;
    @(posedge clk); @(negedge clk);
    wr_data = 8'hFF;
    @(posedge clk); @(negedge clk);
    wr_req = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_outs("prerst beat1", 1,0,1,1,1,2'd1,1);
    #2 arst_l = 1'b0;
    #1;
    check_outs("async rst", 0,0,0,0,1,2'd0,0);
    @(negedge clk);
    arst_l = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      check_outs($sformatf("postrst c%0d", k), 0,0,0,0,1,2'd0,0);
    end

    // first accept right after release yields PRE on the following edge
    wr_req = 1'b1; wr_data = 8'h02; burst_length_four = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_req = 1'b0;
    check_outs("relaunch acc", 0,0,0,0,1,2'd1,1);
    @(posedge clk); @(negedge clk);
    check_outs("relaunch pre", 0,0,1,1,1,2'd1,1);
    @(posedge clk); @(negedge clk);
    check_outs("relaunch b0", 0,1,1,1,1,2'd0,1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_dq_wrser.md
DRAM_DQ_WRSER -- requirements
Module: dram_dq_wrser

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of queued write bursts (power of 2, >=2).
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 arst_l  input  1  asynchronous active-low reset.
REQ-004 wr_req  input  1  write-burst request from controller.
REQ-005 wr_data  input  8  burst bits for one DQ line; bit 0 is transferred first.
REQ-006 burst_length_four  input  1  1 = 4-bit burst (wr_data[3:0] only); 0 = 8-bit burst.
REQ-007 wr_rdy  output  1  buffer can accept; burst accepted when wr_req & wr_rdy.
REQ-008 data_pos  output  1  bit for rising-edge half of DDR beat, to edge logic.
REQ-009 data_neg  output  1  bit for falling-edge half of DDR beat, to edge logic.
REQ-010 dram_io_drive_enable  output  1  pad output driver enable.
REQ-011 dram_io_pad_enable  output  1  pad window enable (covers preamble to postamble).
REQ-012 busy  output  1  high when FSM not IDLE or buffer non-empty.
REQ-013 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  entries queued.

Function
REQ-014 The block SHALL hold a FIFO of {wr_data, burst_length_four}; burst_length_four is sampled per entry at acceptance.
REQ-015 wr_rdy SHALL equal (fifo_cnt != FIFO_DEPTH), combinational from registered count; no accept when full, even if a pop happens the same cycle.
REQ-016 FSM states: IDLE, PRE, BURST, POST; data_pos, data_neg, both enables SHALL be registered.
REQ-017 IDLE -> PRE when FIFO non-empty; PRE lasts 1 cycle: drive_enable=1, pad_enable=1, data_pos=data_neg=0.
REQ-018 PRE -> BURST, head entry popped on entry to BURST; beat k (k=0..N-1) SHALL drive data_pos=wr_data[2k], data_neg=wr_data[2k+1]; N=2 if burst_length_four else 4.
REQ-019 In BURST, drive_enable=1, pad_enable=1; a 2-bit beat counter SHALL reset to 0 on BURST entry and wrap at N-1.
REQ-020 On last beat: if FIFO non-empty, the next entry SHALL be popped and its beat 0 driven the very next cycle (seamless, no POST/PRE); else -> POST.
REQ-021 POST lasts 1 cycle: drive_enable=0, pad_enable=1, data 0; then -> IDLE (or -> PRE if FIFO non-empty).
REQ-022 In IDLE all four pad outputs SHALL be 0.
REQ-023 Latency: accept at edge E0 with empty FIFO and IDLE -> PRE visible after E1, beat 0 after E2.
REQ-024 Simultaneous push and pop SHALL leave fifo_cnt unchanged and preserve order; pointers wrap modulo FIFO_DEPTH.
REQ-025 Mixed burst lengths in queue SHALL each use their own stored length.
REQ-026 Change of burst_length_four input mid-burst SHALL not affect the burst in progress.

Reset
REQ-027 arst_l low SHALL immediately force: state IDLE, FIFO empty, fifo_cnt=0, wr_rdy=1, busy=0, data_pos=data_neg=0, both enables 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst and discard all queued entries; no beat emitted after deassertion until a new request.
REQ-029 Reset deassertion SHALL be used synchronously to clk by downstream logic; first accept allowed on first edge after deassertion.

Verification
REQ-030 Single BL8: wr_data=8'hB4 -> PRE, beats (pos,neg)=(0,0),(1,0),(1,1),(0,1), POST, IDLE; drive_enable high PRE..last beat only.
REQ-031 Single BL4: wr_data=8'hF6, burst_length_four=1 -> beats (0,1),(1,0), then POST; upper nibble never driven.
REQ-032 Back-to-back: push 8'hFF then 8'h00 (BL8) on consecutive cycles -> one PRE, 8 contiguous beats, one POST; drive_enable never drops between bursts.
REQ-033 Full: FIFO_DEPTH=2, three consecutive requests during a burst -> third sees wr_rdy=0 until first pop; all three bursts emitted in order.
REQ-034 Reset mid-burst: assert arst_l at beat 1 with one entry queued -> all outputs 0 asynchronously, fifo_cnt=0; after release, no activity without wr_req.
REQ-035 Mixed lengths: BL4 8'h0A then BL8 8'h55 queued -> 2 beats then 4 beats seamless, each with correct bit order.
